// File: rtl/time_ctl_pkg.sv
// Shared field codes and FSM state encoding for the time-set edit sequencer.
package time_ctl_pkg;

   localparam logic [1:0] FIELD_MS      = 2'd0;
   localparam logic [1:0] FIELD_SEC     = 2'd1;
   localparam logic [1:0] FIELD_MIN     = 2'd2;
   localparam logic [1:0] FIELD_HR      = 2'd3;
   localparam logic [1:0] FIELD_DEFAULT = FIELD_MIN;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_DELAY  = 2'd2,
      ST_REPEAT = 2'd3
   } state_e;

endpackage

// File: rtl/button_edge_detector.sv
// Rising-edge detector for one debounced button level.
module button_edge_detector (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_level,
   output logic o_edge
);

   logic prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) prev <= 1'b0;
      else       prev <= i_level;
   end

   assign o_edge = i_level & ~prev;

endmodule

// File: rtl/time_set_controller.sv
// Edit-mode sequencer: field cursor, up/down strobes with auto-repeat, cursor blink
// and inactivity timeout for the ms/sec/min/hr counter chain.
module time_set_controller
   import time_ctl_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = 500,
   parameter int unsigned REPEAT_RATE  = 100,
   parameter int unsigned BLINK_HALF   = 250,
   parameter int unsigned TIMEOUT      = 10000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tick,
   input  logic       i_set,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_left,
   input  logic       i_right,
   output logic       o_edit,
   output logic [1:0] o_field,
   output logic       o_blink,
   output logic       o_ms_up,
   output logic       o_ms_down,
   output logic       o_sec_up,
   output logic       o_sec_down,
   output logic       o_min_up,
   output logic       o_min_down,
   output logic       o_hr_up,
   output logic       o_hr_down
);

   localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RP_W   = $clog2(RP_MAX + 1);
   localparam int unsigned BL_W   = $clog2(BLINK_HALF + 1);
   localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

   logic e_set, e_up, e_down, e_left, e_right, any_edge;

   button_edge_detector u_set   (.i_clk(i_clk), .i_rst(i_rst), .i_level(i_set),   .o_edge(e_set));
   button_edge_detector u_up    (.i_clk(i_clk), .i_rst(i_rst), .i_level(i_up),    .o_edge(e_up));
   button_edge_detector u_down  (.i_clk(i_clk), .i_rst(i_rst), .i_level(i_down),  .o_edge(e_down));
   button_edge_detector u_left  (.i_clk(i_clk), .i_rst(i_rst), .i_level(i_left),  .o_edge(e_left));
   button_edge_detector u_right (.i_clk(i_clk), .i_rst(i_rst), .i_level(i_right), .o_edge(e_right));

   assign any_edge = e_set | e_up | e_down | e_left | e_right;

   state_e          state_q, state_d;
   logic [1:0]      field_q, field_d;
   logic            dir_up_q, dir_up_d;
   logic [RP_W-1:0] rep_cnt_q, rep_cnt_d, rep_last;
   logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            blink_q, blink_d;
   logic [7:0]      strobe_q, strobe_d;
   logic            fire, move, rep_clr, held_ok, to_hit;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         field_q     <= FIELD_DEFAULT;
         dir_up_q    <= 1'b1;
         rep_cnt_q   <= '0;
         blink_cnt_q <= '0;
         to_cnt_q    <= '0;
         blink_q     <= 1'b0;
         strobe_q    <= '0;
      end else begin
         state_q     <= state_d;
         field_q     <= field_d;
         dir_up_q    <= dir_up_d;
         rep_cnt_q   <= rep_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         to_cnt_q    <= to_cnt_d;
         blink_q     <= blink_d;
         strobe_q    <= strobe_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      field_d  = field_q;
      dir_up_d = dir_up_q;
      fire     = 1'b0;
      move     = 1'b0;
      rep_clr  = 1'b0;
      held_ok  = dir_up_q ? (i_up & ~i_down) : (i_down & ~i_up);
      rep_last = (state_q == ST_DELAY) ? RP_W'(REPEAT_DELAY - 1) : RP_W'(REPEAT_RATE - 1);
      to_hit   = i_tick & (state_q != ST_IDLE) & ~any_edge & (to_cnt_q == TO_W'(TIMEOUT - 1));
      case (state_q)
         ST_IDLE: begin
            if (e_set) begin
               state_d = ST_EDIT;
               field_d = FIELD_DEFAULT;
            end
         end
         ST_EDIT: begin
            if (e_set || to_hit) begin
               state_d = ST_IDLE;
            end else begin
               if (e_left ^ e_right) begin
                  move    = 1'b1;
                  field_d = e_left ? field_q + 2'd1 : field_q - 2'd1;
               end
               if (e_up ^ e_down) begin
                  fire     = 1'b1;
                  dir_up_d = e_up;
                  rep_clr  = 1'b1;
                  state_d  = ST_DELAY;
               end
            end
         end
         ST_DELAY, ST_REPEAT: begin
            if (e_set || to_hit) begin
               state_d = ST_IDLE;
            end else if (!held_ok) begin
               state_d = ST_EDIT;
            end else if (i_tick && (rep_cnt_q == rep_last)) begin
               fire    = 1'b1;
               rep_clr = 1'b1;
               state_d = ST_REPEAT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      rep_cnt_d = rep_cnt_q;
      if (rep_clr)
         rep_cnt_d = '0;
      else if (i_tick && (state_q == ST_DELAY || state_q == ST_REPEAT) && rep_cnt_q < RP_W'(RP_MAX))
         rep_cnt_d = rep_cnt_q + RP_W'(1);

      // strobes count as activity so a held auto-repeat never times out
      to_cnt_d = to_cnt_q;
      if (any_edge || fire)
         to_cnt_d = '0;
      else if (i_tick && state_q != ST_IDLE && to_cnt_q < TO_W'(TIMEOUT))
         to_cnt_d = to_cnt_q + TO_W'(1);
   end

   always_comb begin
      strobe_d = '0;
      if (fire) strobe_d[{field_d, ~dir_up_d}] = 1'b1;

      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      if (state_d == ST_IDLE) begin
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (state_q == ST_IDLE || fire || move) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (i_tick) begin
         if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
         end else if (blink_cnt_q < BL_W'(BLINK_HALF)) begin
            blink_cnt_d = blink_cnt_q + BL_W'(1);
         end
      end
   end

   assign o_edit     = (state_q != ST_IDLE);
   assign o_field    = field_q;
   assign o_blink    = blink_q;
   assign o_ms_up    = strobe_q[{FIELD_MS,  1'b0}];
   assign o_ms_down  = strobe_q[{FIELD_MS,  1'b1}];
   assign o_sec_up   = strobe_q[{FIELD_SEC, 1'b0}];
   assign o_sec_down = strobe_q[{FIELD_SEC, 1'b1}];
   assign o_min_up   = strobe_q[{FIELD_MIN, 1'b0}];
   assign o_min_down = strobe_q[{FIELD_MIN, 1'b1}];
   assign o_hr_up    = strobe_q[{FIELD_HR,  1'b0}];
   assign o_hr_down  = strobe_q[{FIELD_HR,  1'b1}];

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: directed button sequences then random levels.
module tb_time_set_controller;

   localparam int RD = 4;
   localparam int RR = 2;
   localparam int BH = 3;
   localparam int TO = 20;

   localparam logic [4:0] B_S = 5'b10000;
   localparam logic [4:0] B_U = 5'b01000;
   localparam logic [4:0] B_D = 5'b00100;
   localparam logic [4:0] B_L = 5'b00010;
   localparam logic [4:0] B_R = 5'b00001;

   logic clk = 1'b0;
   logic i_rst = 1'b1, i_tick = 1'b0, i_set = 1'b0, i_up = 1'b0, i_down = 1'b0;
   logic i_left = 1'b0, i_right = 1'b0;
   logic o_edit, o_blink;
   logic [1:0] o_field;
   logic o_ms_up, o_ms_down, o_sec_up, o_sec_down, o_min_up, o_min_down, o_hr_up, o_hr_down;

   always #5 clk = ~clk;

   time_set_controller #(
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_HALF(BH), .TIMEOUT(TO)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_tick(i_tick), .i_set(i_set), .i_up(i_up),
      .i_down(i_down), .i_left(i_left), .i_right(i_right),
      .o_edit(o_edit), .o_field(o_field), .o_blink(o_blink),
      .o_ms_up(o_ms_up), .o_ms_down(o_ms_down), .o_sec_up(o_sec_up), .o_sec_down(o_sec_down),
      .o_min_up(o_min_up), .o_min_down(o_min_down), .o_hr_up(o_hr_up), .o_hr_down(o_hr_down)
   );

   typedef struct packed {
      logic       edit;
      logic [1:0] field;
      logic       blink;
      logic [7:0] strb;
   } snap_t;

   snap_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int n_sec_up = 0;

   // reference model: hold = +1 up / -1 down / 0 none, since = ticks into the current hold
   bit m_edit, m_blink, m_rep;
   int m_field, m_bcnt, m_quiet, m_hold, m_since;
   bit p_s, p_u, p_d, p_l, p_r;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model(input bit rs, tk, s, u, d, lf, rt);
      bit es, eu, ed, el, er, any, fire, move, was_edit, to_hit, ok;
      snap_t e;
      if (rs) begin
         m_edit = 0; m_field = 2; m_blink = 0; m_bcnt = 0; m_quiet = 0;
         m_hold = 0; m_since = 0; m_rep = 0;
         {p_s, p_u, p_d, p_l, p_r} = '0;
         e = '{edit: 1'b0, field: 2'd2, blink: 1'b0, strb: 8'h00};
         exp_q.push_back(e);
         return;
      end
      es = s & ~p_s; eu = u & ~p_u; ed = d & ~p_d; el = lf & ~p_l; er = rt & ~p_r;
      {p_s, p_u, p_d, p_l, p_r} = {s, u, d, lf, rt};
      any = es | eu | ed | el | er;
      fire = 0; move = 0; was_edit = m_edit;
      to_hit = tk && m_edit && !any && (m_quiet == TO - 1);
      if (!m_edit) begin
         if (es) begin m_edit = 1; m_field = 2; end
      end else if (es || to_hit) begin
         m_edit = 0; m_hold = 0;
      end else if (m_hold == 0) begin
         if (el != er) begin
            move = 1;
            m_field = el ? (m_field + 1) % 4 : (m_field + 3) % 4;
         end
         if (eu != ed) begin
            fire = 1; m_hold = eu ? 1 : -1; m_since = 0; m_rep = 0;
         end
      end else begin
         ok = (m_hold > 0) ? (u && !d) : (d && !u);
         if (!ok) m_hold = 0;
         else if (tk) begin
            m_since++;
            if (m_since == (m_rep ? RR : RD)) begin
               fire = 1; m_since = 0; m_rep = 1;
            end
         end
      end
      if (any || fire) m_quiet = 0;
      else if (tk && was_edit && m_quiet < TO) m_quiet++;
      if (!m_edit) begin
         m_blink = 0; m_bcnt = 0;
      end else if (!was_edit || fire || move) begin
         m_blink = 1; m_bcnt = 0;
      end else if (tk) begin
         m_bcnt++;
         if (m_bcnt == BH) begin m_blink = !m_blink; m_bcnt = 0; end
      end
      e.edit  = m_edit;
      e.field = 2'(m_field);
      e.blink = m_blink;
      e.strb  = fire ? (8'b1 << (m_field * 2 + ((m_hold < 0) ? 1 : 0))) : 8'b0;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit rs, tk, s, u, d, lf, rt);
      @(negedge clk);
      i_rst = rs; i_tick = tk; i_set = s; i_up = u; i_down = d; i_left = lf; i_right = rt;
      model(rs, tk, s, u, d, lf, rt);
   endtask

   task automatic press(input logic [4:0] b);
      drive(1'b0, 1'b1, b[4], b[3], b[2], b[1], b[0]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) press(5'b0);
   endtask

   initial begin : monitor
      snap_t e;
      logic [7:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {o_hr_down, o_hr_up, o_min_down, o_min_up,
                   o_sec_down, o_sec_up, o_ms_down, o_ms_up};
            if (o_sec_up) n_sec_up++;
            chk("edit",   int'(o_edit),  int'(e.edit));
            chk("field",  int'(o_field), int'(e.field));
            chk("blink",  int'(o_blink), int'(e.blink));
            chk("strobe", int'(act),     int'(e.strb));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [4:0] lv;
      drive(1'b1, 1'b1, 0, 0, 0, 0, 0);
      drive(1'b1, 1'b1, 0, 0, 0, 0, 0);
      idle(3);
      press(B_S); idle(3);
      press(B_S); idle(3);
      press(B_S); idle(2);
      repeat (3) begin press(B_L); idle(2); end
      repeat (2) begin press(B_R); idle(2); end
      press(B_L | B_R); idle(2);
      repeat (2) begin press(B_L); idle(1); end
      n_sec_up = 0;
      repeat (10) press(B_U);
      idle(2);
      @(posedge clk);
      #2;
      chk("sec_up_count", n_sec_up, 4);
      repeat (6) press(B_D);
      repeat (4) press(B_D | B_U);
      idle(4);
      idle(25);
      press(B_S); idle(17);
      press(B_U); idle(25);
      press(B_S); idle(2);
      repeat (9) press(B_U);
      drive(1'b1, 1'b1, 0, 1, 0, 0, 0);
      press(B_U);
      idle(3);

      lv = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(7) == 0) lv[b] = ~lv[b];
         if ($urandom_range(29) == 0) lv[4] = ~lv[4];
         drive(($urandom_range(399) == 0), ($urandom_range(3) != 0),
               lv[4], lv[3], lv[2], lv[1], lv[0]);
      end
      idle(2);
      @(posedge clk);
      #2;
      chk("drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
